// File: rtl/noc_mod_port_pkg.sv
// Shared NoC definitions: default flit field widths and the packet framing state.
package noc_mod_port_pkg;

  localparam int unsigned NOC_HEADER_SIZE_DEF  = 8;
  localparam int unsigned NOC_PAYLOAD_SIZE_DEF = 32;
  localparam int unsigned FLIT_BUF_DEPTH       = 2;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } noc_pkt_state_e;

endpackage

// File: rtl/noc_flit_buf2.sv
// Two-entry flit FIFO; head entry is always visible on rdata, count tracks occupancy.
module noc_flit_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop & (count != 2'd0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/noc_mod_port.sv
// Module-side NoC link endpoint: valid/ready streams to link wrreq/stall and rdreq/empty,
// with two flits of buffering per direction, TX packet framing and packet/flit counters.
module noc_mod_port
  import noc_mod_port_pkg::*;
#(
  parameter int unsigned NOC_HEADER_SIZE  = NOC_HEADER_SIZE_DEF,
  parameter int unsigned NOC_PAYLOAD_SIZE = NOC_PAYLOAD_SIZE_DEF,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_q_i,
  input  logic                        mod_tx_valid_i,
  output logic                        mod_tx_ready_o,
  input  logic [NOC_HEADER_SIZE-1:0]  mod_tx_header_i,
  input  logic [NOC_PAYLOAD_SIZE-1:0] mod_tx_payload_i,
  input  logic                        mod_tx_last_i,
  output logic                        mod_rx_valid_o,
  input  logic                        mod_rx_ready_i,
  output logic [NOC_HEADER_SIZE-1:0]  mod_rx_header_o,
  output logic [NOC_PAYLOAD_SIZE-1:0] mod_rx_payload_o,
  output logic                        link_wrreq_o,
  input  logic                        link_stall_i,
  output logic [NOC_HEADER_SIZE-1:0]  link_header_o,
  output logic [NOC_PAYLOAD_SIZE-1:0] link_payload_o,
  output logic                        link_rdreq_o,
  input  logic                        link_empty_i,
  input  logic [NOC_HEADER_SIZE-1:0]  link_header_i,
  input  logic [NOC_PAYLOAD_SIZE-1:0] link_payload_i,
  output logic                        tx_in_pkt_o,
  output logic [CNT_WIDTH-1:0]        tx_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]        rx_flit_cnt_o
);

  localparam int unsigned FLIT_W = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE;

  logic [1:0]        tx_count;
  logic [1:0]        rx_count;
  logic              tx_accept;
  logic              rx_pop;
  logic [FLIT_W-1:0] tx_head;
  logic [FLIT_W-1:0] rx_head;
  noc_pkt_state_e    state;
  noc_pkt_state_e    state_nxt;
  logic              pkt_done;

  assign mod_tx_ready_o = (tx_count != 2'd2);
  assign tx_accept      = mod_tx_valid_i & mod_tx_ready_o;
  assign link_wrreq_o   = (tx_count != 2'd0) & ~link_stall_i;
  assign {link_header_o, link_payload_o} = tx_head;

  noc_flit_buf2 #(.W(FLIT_W)) u_tx_buf (
    .clk   (clk_i),
    .rst_n (reset_q_i),
    .push  (tx_accept),
    .wdata ({mod_tx_header_i, mod_tx_payload_i}),
    .pop   (link_wrreq_o),
    .rdata (tx_head),
    .count (tx_count)
  );

  // Gated by reset so the link FIFO is never popped while the capture buffer is held clear.
  assign link_rdreq_o   = reset_q_i & ~link_empty_i & (rx_count != 2'd2);
  assign mod_rx_valid_o = (rx_count != 2'd0);
  assign rx_pop         = mod_rx_valid_o & mod_rx_ready_i;
  assign {mod_rx_header_o, mod_rx_payload_o} = rx_head;

  noc_flit_buf2 #(.W(FLIT_W)) u_rx_buf (
    .clk   (clk_i),
    .rst_n (reset_q_i),
    .push  (link_rdreq_o),
    .wdata ({link_header_i, link_payload_i}),
    .pop   (rx_pop),
    .rdata (rx_head),
    .count (rx_count)
  );

  always_ff @(posedge clk_i or negedge reset_q_i) begin
    if (!reset_q_i) begin
      state         <= IDLE;
      tx_pkt_cnt_o  <= '0;
      rx_flit_cnt_o <= '0;
    end else begin
      state         <= state_nxt;
      tx_pkt_cnt_o  <= tx_pkt_cnt_o + CNT_WIDTH'(pkt_done);
      rx_flit_cnt_o <= rx_flit_cnt_o + CNT_WIDTH'(link_rdreq_o);
    end
  end

  // Framing advances only on flits accepted from the module.
  always_comb begin
    state_nxt = state;
    pkt_done  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_accept && !mod_tx_last_i) state_nxt = PKT;
        else if (tx_accept)              pkt_done  = 1'b1;
      end
      PKT: begin
        if (tx_accept && mod_tx_last_i) begin
          state_nxt = IDLE;
          pkt_done  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tx_in_pkt_o = (state == PKT);

endmodule

// File: tb/tb_noc_mod_port.sv
// Self-checking bench for noc_mod_port: per-cycle vector table for TX framing plus
// scoreboarded RX/TX sequences for backpressure, full duplex, wrap and reset.
module tb_noc_mod_port;

  localparam int unsigned HW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned FW = HW + PW;

  logic          clk_i = 1'b0;
  logic          reset_q_i;
  logic          mod_tx_valid_i;
  logic          mod_tx_ready_o;
  logic [HW-1:0] mod_tx_header_i;
  logic [PW-1:0] mod_tx_payload_i;
  logic          mod_tx_last_i;
  logic          mod_rx_valid_o;
  logic          mod_rx_ready_i;
  logic [HW-1:0] mod_rx_header_o;
  logic [PW-1:0] mod_rx_payload_o;
  logic          link_wrreq_o;
  logic          link_stall_i;
  logic [HW-1:0] link_header_o;
  logic [PW-1:0] link_payload_o;
  logic          link_rdreq_o;
  logic          link_empty_i;
  logic [HW-1:0] link_header_i;
  logic [PW-1:0] link_payload_i;
  logic          tx_in_pkt_o;
  logic [CW-1:0] tx_pkt_cnt_o;
  logic [CW-1:0] rx_flit_cnt_o;

  always #5 clk_i = ~clk_i;

  noc_mod_port #(
    .NOC_HEADER_SIZE (HW),
    .NOC_PAYLOAD_SIZE(PW),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk_i           (clk_i),
    .reset_q_i       (reset_q_i),
    .mod_tx_valid_i  (mod_tx_valid_i),
    .mod_tx_ready_o  (mod_tx_ready_o),
    .mod_tx_header_i (mod_tx_header_i),
    .mod_tx_payload_i(mod_tx_payload_i),
    .mod_tx_last_i   (mod_tx_last_i),
    .mod_rx_valid_o  (mod_rx_valid_o),
    .mod_rx_ready_i  (mod_rx_ready_i),
    .mod_rx_header_o (mod_rx_header_o),
    .mod_rx_payload_o(mod_rx_payload_o),
    .link_wrreq_o    (link_wrreq_o),
    .link_stall_i    (link_stall_i),
    .link_header_o   (link_header_o),
    .link_payload_o  (link_payload_o),
    .link_rdreq_o    (link_rdreq_o),
    .link_empty_i    (link_empty_i),
    .link_header_i   (link_header_i),
    .link_payload_i  (link_payload_i),
    .tx_in_pkt_o     (tx_in_pkt_o),
    .tx_pkt_cnt_o    (tx_pkt_cnt_o),
    .rx_flit_cnt_o   (rx_flit_cnt_o)
  );

  typedef struct {
    logic          v;
    logic          last;
    logic          stall;
    logic          e_ready;
    logic          e_wr;
    logic          e_inpkt;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t          tbl[$];
  logic [FW-1:0] tx_exp[$];
  logic [FW-1:0] rx_exp[$];
  logic [FW-1:0] rx_src[$];
  int n_chk = 0;
  int n_pass = 0;
  int tx_seq = 0;
  int wr_cnt = 0, acc_cnt = 0, rd_cnt = 0, dlv_cnt = 0, ready_low = 0;
  bit rx_pop_pend = 0;

  function automatic logic [FW-1:0] mk(input int s);
    return {HW'(s), PW'(s * 7 + 256)};
  endfunction

  function automatic void add(input logic v, input logic l, input logic s, input logic r,
                              input logic w, input logic p, input int c);
    vec_t e;
    e.v = v; e.last = l; e.stall = s; e.e_ready = r; e.e_wr = w; e.e_inpkt = p;
    e.e_cnt = CW'(c);
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_link();
    link_empty_i = (rx_src.size() == 0);
    if (rx_src.size() != 0) {link_header_i, link_payload_i} = rx_src[0];
    else {link_header_i, link_payload_i} = '0;
  endtask

  task automatic drive_tx();
    {mod_tx_header_i, mod_tx_payload_i} = mk(tx_seq);
  endtask

  // Sample at the falling edge: every handshake seen here completes on the next rising edge.
  task automatic mon();
    logic [FW-1:0] f;
    @(negedge clk_i);
    chk("no_wrreq_under_stall", 32'(link_wrreq_o & link_stall_i), 0);
    if (!mod_tx_ready_o && mod_tx_valid_i) ready_low++;
    if (link_wrreq_o) begin
      wr_cnt++;
      chk("tx_exp_avail", 32'(tx_exp.size() != 0), 1);
      if (tx_exp.size() != 0) begin
        f = tx_exp.pop_front();
        chk("tx_data", 32'({link_header_o, link_payload_o}), 32'(f));
      end
    end
    if (mod_tx_valid_i && mod_tx_ready_o) begin
      acc_cnt++;
      tx_exp.push_back({mod_tx_header_i, mod_tx_payload_i});
      tx_seq++;
    end
    if (mod_rx_valid_o && mod_rx_ready_i) begin
      dlv_cnt++;
      chk("rx_exp_avail", 32'(rx_exp.size() != 0), 1);
      if (rx_exp.size() != 0) begin
        f = rx_exp.pop_front();
        chk("rx_data", 32'({mod_rx_header_o, mod_rx_payload_o}), 32'(f));
      end
    end
    if (link_rdreq_o) begin
      rd_cnt++;
      chk("rdreq_src_avail", 32'(rx_src.size() != 0), 1);
      if (rx_src.size() != 0) rx_exp.push_back(rx_src[0]);
      rx_pop_pend = 1;
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
    if (rx_pop_pend) begin
      if (rx_src.size() != 0) void'(rx_src.pop_front());
      rx_pop_pend = 0;
    end
    set_link();
    drive_tx();
  endtask

  task automatic cyc();
    mon();
    adv();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_ready"}, 32'(mod_tx_ready_o), 1);
    chk({tag, "_rx_valid"}, 32'(mod_rx_valid_o), 0);
    chk({tag, "_wrreq"}, 32'(link_wrreq_o), 0);
    chk({tag, "_rdreq"}, 32'(link_rdreq_o), 0);
    chk({tag, "_in_pkt"}, 32'(tx_in_pkt_o), 0);
    chk({tag, "_pkt_cnt"}, 32'(tx_pkt_cnt_o), 0);
    chk({tag, "_flit_cnt"}, 32'(rx_flit_cnt_o), 0);
    chk({tag, "_link_out"}, 32'({link_header_o, link_payload_o}), 0);
    chk({tag, "_rx_out"}, 32'({mod_rx_header_o, mod_rx_payload_o}), 0);
  endtask

  initial begin
    int base_acc, base_wr, base_rd, base_dlv;

    reset_q_i = 1'b0;
    mod_tx_valid_i = 1'b0;
    mod_tx_last_i = 1'b0;
    mod_rx_ready_i = 1'b0;
    link_stall_i = 1'b0;
    set_link();
    drive_tx();
    #12;
    chk_reset_vals("rst");
    @(negedge clk_i);
    reset_q_i = 1'b1;
    adv();

    // TX streaming: 4-flit packet, no stall
    add(1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 0, 0, 1, 1, 1, 0);
    add(1, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1);
    // TX stall: 5 stalled cycles while offering a 3-flit packet
    add(1, 0, 1, 1, 0, 0, 1);
    add(1, 0, 1, 1, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    add(1, 1, 1, 0, 0, 1, 1);
    add(1, 1, 0, 0, 1, 1, 1);
    add(1, 1, 0, 1, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 1, 0, 0, 2);
    // Three single-flit packets
    add(1, 1, 0, 1, 0, 0, 2);
    add(1, 1, 0, 1, 1, 0, 3);
    add(1, 1, 0, 1, 1, 0, 4);
    add(0, 0, 0, 1, 1, 0, 5);
    add(0, 0, 0, 1, 0, 0, 5);

    foreach (tbl[i]) begin
      mod_tx_valid_i = tbl[i].v;
      mod_tx_last_i  = tbl[i].last;
      link_stall_i   = tbl[i].stall;
      mon();
      chk($sformatf("row%0d_ready", i), 32'(mod_tx_ready_o), 32'(tbl[i].e_ready));
      chk($sformatf("row%0d_wrreq", i), 32'(link_wrreq_o), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d_in_pkt", i), 32'(tx_in_pkt_o), 32'(tbl[i].e_inpkt));
      chk($sformatf("row%0d_pkt_cnt", i), 32'(tx_pkt_cnt_o), 32'(tbl[i].e_cnt));
      adv();
    end
    chk("tx_flits_out", 32'(wr_cnt), 10);
    chk("tx_drained", 32'(tx_exp.size()), 0);

    // RX backpressure: 5 flits waiting, module not ready
    mod_tx_valid_i = 1'b0;
    mod_tx_last_i = 1'b0;
    link_stall_i = 1'b0;
    mod_rx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) rx_src.push_back(mk(100 + i));
    set_link();
    base_rd = rd_cnt;
    for (int c = 0; c < 6; c++) begin
      mon();
      chk($sformatf("bp_rdreq_c%0d", c), 32'(link_rdreq_o), 32'(c < 2));
      chk($sformatf("bp_rx_valid_c%0d", c), 32'(mod_rx_valid_o), 32'(c >= 1));
      adv();
    end
    chk("bp_rdreqs", 32'(rd_cnt - base_rd), 2);
    mod_rx_ready_i = 1'b1;
    base_dlv = dlv_cnt;
    for (int k = 0; k < 30 && (dlv_cnt - base_dlv) < 5; k++) cyc();
    chk("bp_delivered", 32'(dlv_cnt - base_dlv), 5);
    chk("bp_flit_cnt", 32'(rx_flit_cnt_o), 5);

    // Full duplex: 100 flits each way, 4-flit packets
    for (int i = 0; i < 100; i++) rx_src.push_back(mk(200 + i));
    set_link();
    base_acc = acc_cnt; base_wr = wr_cnt; base_rd = rd_cnt; base_dlv = dlv_cnt;
    ready_low = 0;
    for (int c = 0; c < 102; c++) begin
      mod_tx_valid_i = ((acc_cnt - base_acc) < 100);
      mod_tx_last_i  = (((acc_cnt - base_acc) % 4) == 3);
      mon();
      adv();
    end
    chk("fd_tx_accepts", 32'(acc_cnt - base_acc), 100);
    chk("fd_wrreqs", 32'(wr_cnt - base_wr), 100);
    chk("fd_rdreqs", 32'(rd_cnt - base_rd), 100);
    chk("fd_delivered", 32'(dlv_cnt - base_dlv), 100);
    chk("fd_ready_low", 32'(ready_low), 0);
    chk("fd_pkt_cnt", 32'(tx_pkt_cnt_o), 14);
    chk("fd_flit_cnt", 32'(rx_flit_cnt_o), 9);

    // Reset with two flits buffered in each direction
    mod_tx_valid_i = 1'b1;
    mod_tx_last_i = 1'b0;
    link_stall_i = 1'b1;
    mod_rx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) rx_src.push_back(mk(400 + i));
    set_link();
    for (int c = 0; c < 3; c++) cyc();
    chk("pre_rst_tx_full", 32'(mod_tx_ready_o), 0);
    chk("pre_rst_rx_valid", 32'(mod_rx_valid_o), 1);
    chk("pre_rst_in_pkt", 32'(tx_in_pkt_o), 1);
    link_stall_i = 1'b0;
    mod_tx_valid_i = 1'b0;
    #1 reset_q_i = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    tx_exp.delete();
    rx_exp.delete();
    rx_src.delete();
    rx_pop_pend = 0;
    set_link();
    @(negedge clk_i);
    reset_q_i = 1'b1;
    adv();

    // RX counter wrap at 4 bits: 17 flits -> 1
    mod_rx_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) rx_src.push_back(mk(500 + i));
    set_link();
    base_dlv = dlv_cnt;
    for (int k = 0; k < 40 && (dlv_cnt - base_dlv) < 17; k++) cyc();
    chk("wrap_delivered", 32'(dlv_cnt - base_dlv), 17);
    chk("wrap_flit_cnt", 32'(rx_flit_cnt_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
